// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with a one-byte holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a live o_parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_read,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    r_sync;
  logic          w_rxs;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_deliver;
  logic          w_ferr;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_overrun;
  logic          r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bad;
  logic          w_par_bad_nxt;
  logic          w_perr;
  logic          r_parity_err;
`endif

  assign w_rxs = r_sync[1];

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  // Frame FSM state, bit timing counter, bit index and shift register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  // Next-state logic; the counter restarts at every sample point.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + ONE;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr        = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = (^r_shift) ^ w_rxs;
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
`ifdef UART_RX_PARITY_EN
          else if (r_par_bad) begin
            w_perr      = 1'b1;
            w_state_nxt = S_IDLE;
          end
`endif
          else begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register: a delivery only lands if the slot is free or being read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_deliver) begin
      if (!r_valid || i_read) begin
        r_data    <= r_shift;
        r_valid   <= 1'b1;
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (i_read) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  // Single-cycle error pulses follow the stop sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_perr;
`endif
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed frames.
// Covers glitch, framing error, overrun, mid-frame reset and parity.
module tb_uart_rx;
  localparam int N = 434;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 4126 + N;
`else
  localparam int LAT = 4126;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       ovr;
  logic       ferr;
  logic       perr;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx(rx),
    .i_read(rd),
    .o_data(data),
    .o_valid(valid),
    .o_overrun(ovr),
    .o_frame_err(ferr),
    .o_parity_err(perr)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  valid_cyc = 0;
  int  c0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic handle(input logic [1:0] kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event: got kind %0d data %0h expected none",
               kind, d);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", 32'(kind), 32'(e.kind));
      chk("event data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: kind 0 = byte, 1 = frame error, 2 = parity error
  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !pv) begin
        valid_cyc = cyc;
        handle(2'd0, data);
      end
      if (ferr) handle(2'd1, 8'h00);
      if (perr) handle(2'd2, 8'h00);
      pv = valid;
    end
  end

  task automatic bit_t(input logic b);
    rx = b;
    repeat (N) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int stop_low);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_t(^d);
`endif
    for (int i = 0; i < stop_low; i++) bit_t(1'b0);
    bit_t(1'b1);
  endtask

  task automatic read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    rx  = 1'b1;
    rd  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset data", 32'(data), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset overrun", 32'(ovr), 32'h0);
    chk("reset frame_err", 32'(ferr), 32'h0);
    chk("reset parity_err", 32'(perr), 32'h0);

    // 1: basic frame and latency
    push(2'd0, 8'h55);
    c0 = cyc;
    send(8'h55, 0);
    idle(20);
    chk("latency", 32'(valid_cyc - c0), 32'(LAT));
    chk("t1 valid", 32'(valid), 32'h1);
    read();
    chk("t1 read clears", 32'(valid), 32'h0);

    // 2: start glitch
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * N);
    chk("glitch no valid", 32'(valid), 32'h0);
    push(2'd0, 8'hA5);
    send(8'hA5, 0);
    idle(20);
    read();

    // 3: framing error and break
    push(2'd1, 8'h00);
    send(8'h3C, 2);
    idle(N);
    chk("ferr no valid", 32'(valid), 32'h0);
    push(2'd0, 8'h81);
    send(8'h81, 0);
    idle(20);
    read();

    // 4: overrun
    push(2'd0, 8'h12);
    send(8'h12, 0);
    idle(20);
    send(8'h34, 0);
    idle(20);
    chk("ovr data", 32'(data), 32'h12);
    chk("ovr valid", 32'(valid), 32'h1);
    chk("ovr flag", 32'(ovr), 32'h1);
    read();
    chk("ovr read valid", 32'(valid), 32'h0);
    chk("ovr read flag", 32'(ovr), 32'h0);

    // 5: reset during data bit 4 of 0xF0
    bit_t(1'b0);
    for (int i = 0; i < 4; i++) bit_t(1'b0);
    rx = 1'b1;
    repeat (N / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst data", 32'(data), 32'h0);
    chk("mid rst valid", 32'(valid), 32'h0);
    chk("mid rst overrun", 32'(ovr), 32'h0);
    chk("mid rst frame_err", 32'(ferr), 32'h0);
    chk("mid rst parity_err", 32'(perr), 32'h0);
    idle(5 * N);
    push(2'd0, 8'h0F);
    send(8'h0F, 0);
    idle(20);
    read();

`ifdef UART_RX_PARITY_EN
    // 6: parity
    push(2'd2, 8'h00);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(i < 3);
    bit_t(1'b0);
    bit_t(1'b1);
    idle(20);
    chk("perr no valid", 32'(valid), 32'h0);
    push(2'd0, 8'h07);
    send(8'h07, 0);
    idle(20);
    chk("par ok valid", 32'(valid), 32'h1);
    read();
`endif

    idle(10);
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
